// File: rtl/sprite_line_fetcher_if.sv
// Memory-side buses of the sprite line fetcher: attribute table read port and
// sprite pattern RAM read port.
interface sprite_line_fetcher_if #(parameter int ATTR_AW = 6);
  logic [ATTR_AW-1:0] attr_addr;
  logic [25:0]        attr_data;
  logic               spr_ren;
  logic [12:0]        spr_raddr;
  logic [1:0]         spr_rdata;

  modport master (output attr_addr, input attr_data,
                  output spr_ren, output spr_raddr, input spr_rdata);
  modport slave  (input attr_addr, output attr_data,
                  input spr_ren, input spr_raddr, output spr_rdata);
endinterface

// File: rtl/sprite_line_fetcher.sv
// Scanline sprite engine: scans attributes for line N+1, fetches sprite rows
// into a back slot bank, and mixes the front bank into a per-pixel colour.

module sprite_slot_px (
  input  logic             vld,
  input  logic [9:0]       x,
  input  logic [15:0][1:0] pix,
  input  logic [9:0]       ax,
  output logic [1:0]       col
);
  logic [9:0] off;
  assign off = ax - x;
  assign col = (vld && off < 10'd16) ? pix[off[3:0]] : 2'd0;
endmodule

module sprite_line_fetcher #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int ATTR_AW      = $clog2(NUM_SPRITES)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 line_start,
  input  logic [9:0]           next_y,
  input  logic                 pixel_en,
  input  logic [9:0]           active_x,
  sprite_line_fetcher_if.master mem,
  output logic [1:0]           pix_out,
  output logic                 pix_valid,
  output logic                 overflow,
  output logic                 busy
);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int SW = $clog2(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN_A, SCAN_B, FETCH} state_t;
  state_t state, state_n;

  logic [ATTR_AW-1:0] idx_i;
  logic [CW-1:0]      cnt;
  logic [4:0]         fcnt;
  logic [9:0]         cur_y;
  logic [4:0]         f_idx;
  logic [3:0]         f_row;
  logic               front, back;

  logic [1:0][MAX_PER_LINE-1:0]             valid;
  logic [1:0][MAX_PER_LINE-1:0][9:0]        xpos;
  logic [1:0][MAX_PER_LINE-1:0][15:0][1:0]  pix;

  logic [9:0]    attr_row;
  logic          hit, last, room;
  logic [SW-1:0] sidx;
  logic [3:0]    wcol;

  assign back     = ~front;
  assign attr_row = cur_y - mem.attr_data[19:10];
  assign hit      = mem.attr_data[25] && attr_row < 10'd16;
  assign last     = idx_i == ATTR_AW'(NUM_SPRITES - 1);
  assign room     = cnt < CW'(MAX_PER_LINE);
  assign sidx     = cnt[SW-1:0];
  // RAM data lags the address by one cycle, so fetch step n writes column n-1
  assign wcol     = fcnt[3:0] - 4'd1;

  assign mem.attr_addr = idx_i;
  assign mem.spr_ren   = (state == FETCH) && !fcnt[4];
  assign mem.spr_raddr = {f_idx, f_row, fcnt[3:0]};
  assign busy          = state != IDLE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = IDLE;
      SCAN_A: state_n = SCAN_B;
      SCAN_B: begin
        if (hit)       state_n = room ? FETCH : IDLE;
        else if (last) state_n = IDLE;
        else           state_n = SCAN_A;
      end
      FETCH:  if (fcnt == 5'd16) state_n = last ? IDLE : SCAN_A;
      default: state_n = IDLE;
    endcase
    if (line_start) state_n = SCAN_A;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_i    <= '0;
      cnt      <= '0;
      fcnt     <= '0;
      cur_y    <= '0;
      f_idx    <= '0;
      f_row    <= '0;
      front    <= 1'b0;
      overflow <= 1'b0;
      valid    <= '0;
    end else if (line_start) begin
      // old front becomes the new back bank and must start empty
      front        <= back;
      valid[front] <= '0;
      overflow     <= 1'b0;
      cur_y        <= next_y;
      idx_i        <= '0;
      cnt          <= '0;
      fcnt         <= '0;
    end else begin
      case (state)
        SCAN_B: begin
          if (hit) begin
            if (room) begin
              f_idx <= mem.attr_data[24:20];
              f_row <= attr_row[3:0];
              fcnt  <= '0;
            end else begin
              overflow <= 1'b1;
            end
          end else if (!last) begin
            idx_i <= idx_i + 1'b1;
          end
        end
        FETCH: begin
          fcnt <= fcnt + 5'd1;
          if (fcnt == 5'd16) begin
            valid[back][sidx] <= 1'b1;
            cnt <= cnt + 1'b1;
            if (!last) idx_i <= idx_i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!line_start && state == SCAN_B && hit && room)
      xpos[back][sidx] <= mem.attr_data[9:0];
    if (!line_start && state == FETCH && fcnt != 5'd0)
      pix[back][sidx][wcol] <= mem.spr_rdata;
  end

  logic [MAX_PER_LINE-1:0][1:0] slot_col;
  logic [1:0]                   win;

  for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
    sprite_slot_px u_px (
      .vld (valid[front][s]),
      .x   (xpos[front][s]),
      .pix (pix[front][s]),
      .ax  (active_x),
      .col (slot_col[s])
    );
  end

  // slots fill in attribute order, so the lowest non-transparent slot wins
  always_comb begin
    win = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--)
      if (slot_col[s] != 2'd0) win = slot_col[s];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= pixel_en;
      pix_out   <= pixel_en ? win : 2'd0;
    end
  end
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: models attribute table and pattern
// RAM, scoreboards expected pixel colours from a reference sprite model.
module tb_sprite_line_fetcher;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_y = '0;
  logic       pixel_en = 1'b0;
  logic [9:0] active_x = '0;
  logic [1:0] pix_out;
  logic       pix_valid, overflow, busy;

  sprite_line_fetcher_if mif ();

  sprite_line_fetcher dut (
    .clk(clk), .resetn(resetn), .line_start(line_start), .next_y(next_y),
    .pixel_en(pixel_en), .active_x(active_x), .mem(mif),
    .pix_out(pix_out), .pix_valid(pix_valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [25:0] attr_mem [64];
  logic [1:0]  ram [8192];
  logic [12:0] raddr_log [$];
  int          ren_cnt = 0;

  always @(posedge clk) begin
    mif.attr_data <= attr_mem[mif.attr_addr];
    if (mif.spr_ren) begin
      mif.spr_rdata <= ram[mif.spr_raddr];
      raddr_log.push_back(mif.spr_raddr);
      ren_cnt <= ren_cnt + 1;
    end
  end

  int checks = 0;
  int passes = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] model(input int y, input int x);
    int hits = 0;
    logic [1:0] res = 2'd0;
    for (int i = 0; i < 64; i++) begin
      logic [25:0] a;
      int row, off;
      a = attr_mem[i];
      if (!a[25]) continue;
      row = (y - int'(a[19:10])) & 1023;
      if (row >= 16) continue;
      if (hits == 8) break;
      hits++;
      off = (x - int'(a[9:0])) & 1023;
      if (off < 16 && res == 2'd0)
        res = ram[(int'(a[24:20]) << 8) | (row << 4) | off];
    end
    return res;
  endfunction

  function automatic int ra(input int idx, input int row, input int col);
    return (idx << 8) | (row << 4) | col;
  endfunction

  task automatic set_attr(input int i, input bit en, input int idx, input int y, input int x);
    attr_mem[i] = {en, 5'(idx), 10'(y), 10'(x)};
  endtask

  task automatic clear_attrs();
    for (int i = 0; i < 64; i++) attr_mem[i] = '0;
  endtask

  task automatic line(input int ny);
    @(negedge clk);
    line_start = 1'b1;
    next_y = 10'(ny);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  // scoreboarded pixel sweep of line y over columns x0..x1
  task automatic run_px(input string tag, input int y, input int x0, input int x1);
    for (int x = x0; x <= x1 + 1; x++) begin
      @(negedge clk);
      if (pix_valid) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, 32'd1, 32'd0);
        else check(tag, {30'd0, pix_out}, {30'd0, exp_q.pop_front()});
      end
      if (x <= x1) begin
        pixel_en = 1'b1;
        active_x = 10'(x & 1023);
        exp_q.push_back(model(y, x));
      end else begin
        pixel_en = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_idle_valid"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_idle_pix"}, {30'd0, pix_out}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic px_const(input string tag, input int x, input int exp);
    @(negedge clk);
    pixel_en = 1'b1;
    active_x = 10'(x);
    @(negedge clk);
    pixel_en = 1'b0;
    check({tag, "_valid"}, {31'd0, pix_valid}, 32'd1);
    check(tag, {30'd0, pix_out}, 32'(exp));
  endtask

  initial begin
    int base, n, ren0;
    mif.attr_data = '0;
    mif.spr_rdata = '0;
    clear_attrs();
    for (int a = 0; a < 8192; a++) ram[a] = 2'((a ^ (a >> 2) ^ (a >> 7)) & 3);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pix_out", {30'd0, pix_out}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_spr_ren", {31'd0, mif.spr_ren}, 32'd0);
    check("rst_attr_addr", {26'd0, mif.attr_addr}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: single sprite fetch and display
    set_attr(0, 1, 3, 100, 50);
    base = raddr_log.size();
    line(105);
    wait_idle("t1_idle");
    check("t1_nfetch", raddr_log.size() - base, 32'd16);
    for (int c = 0; c < 16; c++)
      check("t1_raddr", {19'd0, raddr_log[base + c]}, 32'(ra(3, 5, c)));
    check("t1_overflow", {31'd0, overflow}, 32'd0);
    line(200);
    px_const("t1_x49", 49, 0);
    px_const("t1_x50", 50, ram[ra(3, 5, 0)]);
    px_const("t1_x66", 66, 0);
    run_px("t1_px", 105, 45, 70);
    wait_idle("t1_idle2");

    // 2: overflow after eight hits
    clear_attrs();
    for (int i = 0; i < 10; i++) set_attr(i, 1, i, 0, i * 20);
    base = raddr_log.size();
    line(3);
    wait_idle("t2_idle");
    check("t2_nfetch", raddr_log.size() - base, 32'd128);
    check("t2_last_idx", {27'd0, raddr_log[raddr_log.size() - 1][12:8]}, 32'd7);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    line(300);
    check("t2_overflow_clr", {31'd0, overflow}, 32'd0);
    run_px("t2_px", 3, 0, 180);
    wait_idle("t2_idle2");

    // 3: priority between overlapping sprites
    clear_attrs();
    for (int c = 0; c < 16; c++) begin
      ram[ra(1, 0, c)] = (c == 0) ? 2'd0 : 2'd1;
      ram[ra(2, 0, c)] = 2'd2;
    end
    set_attr(0, 1, 1, 0, 10);
    set_attr(1, 1, 2, 0, 5);
    line(0);
    wait_idle("t3_idle");
    line(1);
    px_const("t3_x10", 10, 2);
    px_const("t3_x11", 11, 1);
    run_px("t3_px", 0, 0, 25);
    wait_idle("t3_idle2");

    // 4: vertical and horizontal wrap
    clear_attrs();
    ram[ra(4, 9, 7)] = 2'd3;
    set_attr(0, 1, 4, 1020, 1020);
    base = raddr_log.size();
    line(5);
    wait_idle("t4_idle");
    check("t4_row", {28'd0, raddr_log[base][7:4]}, 32'd9);
    check("t4_idx", {27'd0, raddr_log[base][12:8]}, 32'd4);
    line(6);
    px_const("t4_x3", 3, 3);
    run_px("t4_px_hi", 5, 1010, 1023);
    run_px("t4_px_lo", 5, 0, 20);
    wait_idle("t4_idle2");

    // 5: abort mid-fetch, then reset mid-line
    clear_attrs();
    for (int c = 0; c < 16; c++) begin
      ram[ra(5, 2, c)] = 2'd3;
      ram[ra(5, 10, c)] = 2'd1;
    end
    set_attr(3, 1, 5, 50, 100);
    line(52);
    repeat (15) @(negedge clk);
    check("t5_in_fetch", {31'd0, mif.spr_ren}, 32'd1);
    check("t5_addr_pre", {26'd0, mif.attr_addr}, 32'd3);
    line(60);
    check("t5_rescan_addr", {26'd0, mif.attr_addr}, 32'd0);
    check("t5_rescan_busy", {31'd0, busy}, 32'd1);
    for (int x = 100; x < 116; x += 5) px_const("t5_aborted", x, 0);
    wait_idle("t5_idle");
    line(61);
    pixel_en = 1'b1;
    active_x = 10'd100;
    repeat (12) @(negedge clk);
    check("t5_pre_rst_pix", {30'd0, pix_out}, 32'd1);
    check("t5_pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t5_rst_pix", {30'd0, pix_out}, 32'd0);
    check("t5_rst_valid", {31'd0, pix_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    pixel_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // 6: all sprites disabled
    clear_attrs();
    ren0 = ren_cnt;
    line(7);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("t6_busy_len", n, 32'd128);
    check("t6_no_ren", ren_cnt - ren0, 32'd0);
    line(8);
    run_px("t6_px", 7, 0, 40);
    wait_idle("t6_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
